// File: rtl/cp0_pkg.sv
// Shared types and constants for the CP0 exception/interrupt controller.
package cp0_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_ENTER  = 2'd2,
    ST_RETURN = 2'd3
  } state_t;

  typedef enum logic {
    KIND_EXC = 1'b0,
    KIND_RET = 1'b1
  } kind_t;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_IM_LO  = 8;
  localparam int STATUS_IM_HI  = 10;
  localparam int CAUSE_EXC_LO  = 2;
  localparam int CAUSE_EXC_HI  = 6;
  localparam int CAUSE_IP_LO   = 8;
  localparam int CAUSE_IP_HI   = 10;

endpackage

// File: rtl/cp0_regs.sv
// Status/Cause/EPC storage with field write masks and the mfc0 read mux.
module cp0_regs
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  int_req,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        enter,
  input  logic [31:0] enter_epc,
  input  logic [4:0]  enter_code,
  input  logic        leave,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc
);

  logic [2:0]  im_reg;
  logic        exl_reg;
  logic        ie_reg;
  logic [4:0]  exc_code_reg;
  logic [2:0]  ip_reg;
  logic [31:0] epc_reg;

  // IP tracks the interrupt lines even while reset is held.
  always_ff @(posedge clk) begin
    ip_reg <= int_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_reg       <= '0;
      exl_reg      <= 1'b0;
      ie_reg       <= 1'b0;
      exc_code_reg <= '0;
      epc_reg      <= '0;
    end else if (enter) begin
      epc_reg      <= enter_epc;
      exc_code_reg <= enter_code;
      exl_reg      <= 1'b1;
    end else if (leave) begin
      exl_reg      <= 1'b0;
    end else if (wr_en) begin
      if (wr_addr == CP0_STATUS) begin
        im_reg  <= wr_data[STATUS_IM_HI:STATUS_IM_LO];
        exl_reg <= wr_data[STATUS_EXL];
        ie_reg  <= wr_data[STATUS_IE];
      end else if (wr_addr == CP0_EPC) begin
        epc_reg <= wr_data;
      end
    end
  end

  always_comb begin
    status = '0;
    status[STATUS_IM_HI:STATUS_IM_LO] = im_reg;
    status[STATUS_EXL]                = exl_reg;
    status[STATUS_IE]                 = ie_reg;
    cause = '0;
    cause[CAUSE_IP_HI:CAUSE_IP_LO]    = ip_reg;
    cause[CAUSE_EXC_HI:CAUSE_EXC_LO]  = exc_code_reg;
    epc = epc_reg;
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CP0_STATUS: rd_data = status;
      CP0_CAUSE:  rd_data = cause;
      CP0_EPC:    rd_data = epc;
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Sequences syscall/eret/interrupt entry: drain, flush, CP0 update, fetch redirect.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [31:0] pc_wb,
  input  logic        syscall_wb,
  input  logic        eret_wb,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_wdata,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_rdata,
  input  logic [2:0]  int_req,
  input  logic        pipe_empty,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] status_out,
  output logic [31:0] cause_out,
  output logic [31:0] epc_out
);

  state_t      state_reg;
  kind_t       kind_reg;
  logic [4:0]  code_reg;
  logic [31:0] epc_next_reg;

  logic irq_pending;
  logic take_sys;
  logic take_eret;
  logic take_irq;
  logic event_any;
  logic reg_wr_en;

  assign irq_pending = (|(int_req & status_out[STATUS_IM_HI:STATUS_IM_LO]))
                       & status_out[STATUS_IE] & ~status_out[STATUS_EXL];

  assign take_sys  = (state_reg == ST_IDLE) & wb_valid & syscall_wb;
  assign take_eret = (state_reg == ST_IDLE) & wb_valid & eret_wb & ~syscall_wb;
  assign take_irq  = (state_reg == ST_IDLE) & wb_valid & irq_pending
                     & ~syscall_wb & ~eret_wb;
  assign event_any = take_sys | take_eret | take_irq;
  // An mtc0 retiring alongside an event is dropped.
  assign reg_wr_en = (state_reg == ST_IDLE) & wb_valid & mtc0_we & ~event_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      kind_reg       <= KIND_EXC;
      code_reg       <= EXC_INT;
      epc_next_reg   <= '0;
      stall          <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      case (state_reg)
        ST_IDLE: begin
          stall <= 1'b0;
          if (event_any) begin
            state_reg <= ST_DRAIN;
            stall     <= 1'b1;
            flush     <= 1'b1;
            if (take_eret) begin
              kind_reg <= KIND_RET;
            end else begin
              kind_reg     <= KIND_EXC;
              code_reg     <= take_sys ? EXC_SYS : EXC_INT;
              epc_next_reg <= pc_wb + 32'd4;
            end
          end
        end
        ST_DRAIN: begin
          stall <= 1'b1;
          if (pipe_empty) begin
            state_reg      <= (kind_reg == KIND_EXC) ? ST_ENTER : ST_RETURN;
            redirect_valid <= 1'b1;
            redirect_pc    <= (kind_reg == KIND_EXC) ? VECTOR_ADDR : epc_out;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          stall     <= 1'b0;
        end
      endcase
    end
  end

  cp0_regs u_regs (
    .clk        (clk),
    .rst        (rst),
    .int_req    (int_req),
    .wr_en      (reg_wr_en),
    .wr_addr    (mtc0_addr),
    .wr_data    (mtc0_wdata),
    .enter      (state_reg == ST_ENTER),
    .enter_epc  (epc_next_reg),
    .enter_code (code_reg),
    .leave      (state_reg == ST_RETURN),
    .rd_addr    (mfc0_addr),
    .rd_data    (mfc0_rdata),
    .status     (status_out),
    .cause      (cause_out),
    .epc        (epc_out)
  );

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: syscall, eret, interrupt, mtc0 masking, reset abort.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [31:0] pc_wb;
  logic        syscall_wb;
  logic        eret_wb;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_rdata;
  logic [2:0]  int_req;
  logic        pipe_empty;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] status_out;
  logic [31:0] cause_out;
  logic [31:0] epc_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .wb_valid       (wb_valid),
    .pc_wb          (pc_wb),
    .syscall_wb     (syscall_wb),
    .eret_wb        (eret_wb),
    .mtc0_we        (mtc0_we),
    .mtc0_addr      (mtc0_addr),
    .mtc0_wdata     (mtc0_wdata),
    .mfc0_addr      (mfc0_addr),
    .mfc0_rdata     (mfc0_rdata),
    .int_req        (int_req),
    .pipe_empty     (pipe_empty),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .status_out     (status_out),
    .cause_out      (cause_out),
    .epc_out        (epc_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic s, input logic f,
                         input logic rv, input logic [31:0] rpc);
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, s});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, f});
    chk({tag, ".rv"},    {31'd0, redirect_valid}, {31'd0, rv});
    chk({tag, ".rpc"},   redirect_pc, rpc);
    $display("step %-12s stall=%0b flush=%0b rv=%0b rpc=%h st=%h ca=%h epc=%h",
             tag, stall, flush, redirect_valid, redirect_pc, status_out, cause_out, epc_out);
  endtask

  task automatic idle_inputs();
    wb_valid   = 1'b0;
    syscall_wb = 1'b0;
    eret_wb    = 1'b0;
    mtc0_we    = 1'b0;
    mtc0_addr  = 5'd0;
    mtc0_wdata = 32'd0;
  endtask

  task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1'b1; mtc0_we = 1'b1; mtc0_addr = a; mtc0_wdata = d; pc_wb = 32'h80;
    tick();
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1; pc_wb = '0; mfc0_addr = 5'd13; int_req = 3'b101; pipe_empty = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    tick();
    // Reset / idle state
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset.status", status_out, 32'h0);
    chk("reset.epc", epc_out, 32'h0);
    chk("reset.cause", cause_out, 32'h0000_0500);
    chk("reset.mfc0_13", mfc0_rdata, 32'h0000_0500);
    mfc0_addr = 5'd5; #1;
    chk("mfc0_unmapped", mfc0_rdata, 32'h0);
    int_req = 3'b000;
    tick();
    chk("ip_follow", cause_out, 32'h0);

    // Syscall at 0x100, pipe already empty
    wb_valid = 1'b1; syscall_wb = 1'b1; pc_wb = 32'h100;
    tick(); idle_inputs();
    chk_ctl("sys.t1", 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    chk_ctl("sys.t2", 1'b1, 1'b0, 1'b1, 32'h3000);
    chk("sys.t2.status", status_out, 32'h0);
    tick();
    chk_ctl("sys.t3", 1'b0, 1'b0, 1'b0, 32'h0);
    chk("sys.epc", epc_out, 32'h104);
    chk("sys.cause", cause_out, 32'h20);
    chk("sys.status", status_out, 32'h2);
    mfc0_addr = 5'd14; #1;
    chk("sys.mfc0_epc", mfc0_rdata, 32'h104);

    // Eret with pipe_empty low for 3 cycles; an mtc0 mid-drain is ignored
    wb_valid = 1'b1; eret_wb = 1'b1; pipe_empty = 1'b0;
    tick(); idle_inputs();
    chk_ctl("eret.t1", 1'b1, 1'b1, 1'b0, 32'h0);
    wb_valid = 1'b1; mtc0_we = 1'b1; mtc0_addr = 5'd14; mtc0_wdata = 32'h55;
    tick(); idle_inputs();
    chk_ctl("eret.t2", 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk_ctl("eret.t3", 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    pipe_empty = 1'b1;
    chk_ctl("eret.t4", 1'b1, 1'b0, 1'b0, 32'h0);
    chk("eret.t4.epc", epc_out, 32'h104);
    tick();
    chk_ctl("eret.t5", 1'b1, 1'b0, 1'b1, 32'h104);
    tick();
    chk_ctl("eret.t6", 1'b0, 1'b0, 1'b0, 32'h0);
    chk("eret.status", status_out, 32'h0);

    // mtc0 write masks
    do_mtc0(5'd12, 32'hFFFF_FFFF);
    mfc0_addr = 5'd12; #1;
    chk("mtc0.mask", mfc0_rdata, 32'h0000_0703);
    do_mtc0(5'd13, 32'hFFFF_FFFF);
    chk("mtc0.cause_ro", cause_out, 32'h20);

    // EXL=1 blocks interrupt
    int_req = 3'b010; wb_valid = 1'b1; pc_wb = 32'h200;
    tick(); idle_inputs();
    chk_ctl("irq.exl", 1'b0, 1'b0, 1'b0, 32'h0);
    // IM=0 blocks interrupt
    int_req = 3'b000;
    do_mtc0(5'd12, 32'h0000_0001);
    int_req = 3'b010; wb_valid = 1'b1; pc_wb = 32'h200;
    tick(); idle_inputs();
    chk_ctl("irq.im0", 1'b0, 1'b0, 1'b0, 32'h0);
    do_mtc0(5'd12, 32'h0000_0201);
    chk("irq.status", status_out, 32'h201);
    tick();
    chk_ctl("irq.nowb", 1'b0, 1'b0, 1'b0, 32'h0);
    wb_valid = 1'b1; pc_wb = 32'h200;
    tick(); idle_inputs();
    chk_ctl("irq.t1", 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    chk_ctl("irq.t2", 1'b1, 1'b0, 1'b1, 32'h3000);
    tick();
    chk("irq.epc", epc_out, 32'h204);
    chk("irq.cause", cause_out, 32'h200);
    chk("irq.status2", status_out, 32'h203);
    int_req = 3'b000;

    // Syscall + mtc0 EPC together at wrapping PC, while EXL=1
    wb_valid = 1'b1; syscall_wb = 1'b1; pc_wb = 32'hFFFF_FFFC;
    mtc0_we = 1'b1; mtc0_addr = 5'd14; mtc0_wdata = 32'hDEAD_BEEF;
    tick(); idle_inputs();
    chk_ctl("wrap.t1", 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    chk_ctl("wrap.t2", 1'b1, 1'b0, 1'b1, 32'h3000);
    tick();
    chk("wrap.epc", epc_out, 32'h0);
    chk("wrap.cause", cause_out, 32'h20);

    // Reset during DRAIN aborts without CP0 update
    pipe_empty = 1'b0; wb_valid = 1'b1; syscall_wb = 1'b1; pc_wb = 32'h400;
    tick(); idle_inputs();
    chk_ctl("rstd.t1", 1'b1, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    chk_ctl("rstd.rst", 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0; pipe_empty = 1'b1;
    tick();
    chk_ctl("rstd.a1", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_ctl("rstd.a2", 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rstd.status", status_out, 32'h0);
    chk("rstd.epc", epc_out, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Exception and interrupt controller owning the CP0 Status (12), Cause (13) and EPC (14) registers of the pipelined MIPS core. It watches instructions retiring at WB (syscall, eret, mtc0) and level interrupt lines. It drains and flushes the pipeline, then updates CP0 and redirects fetch to the handler vector or back to EPC. It replaces ad-hoc CP0 writes inside the register file with a single sequenced owner.

## Interface
- VECTOR_ADDR, 32'h0000_3000: handler entry PC.
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  a real instruction retires at WB this cycle.
- pc_wb  in  32  PC of the retiring instruction.
- syscall_wb  in  1  retiring instruction is syscall.
- eret_wb  in  1  retiring instruction is eret.
- mtc0_we  in  1  retiring mtc0.
- mtc0_addr  in  5  CP0 register number.
- mtc0_wdata  in  32  mtc0 data.
- mfc0_addr  in  5  read address from ID.
- mfc0_rdata  out  32  combinational read data; 0 for unmapped addresses.
- int_req  in  3  level-sensitive interrupt lines.
- pipe_empty  in  1  no valid instruction in IF..MEM.
- stall  out  1  freeze IF/ID.
- flush  out  1  one-cycle pipeline kill.
- redirect_valid  out  1  one-cycle PC override.
- redirect_pc  out  32  override target.
- status_out, cause_out, epc_out  out  32 each  live register values.

## Operation
- Status fields: IM = [10:8], EXL = [1], IE = [0]. Other bits read 0.
- Cause fields: IP = [10:8], ExcCode = [6:2]. Other bits read 0.
- IP is read-only and copies int_req every cycle, including during reset release.
- irq_pending = |(int_req & Status[10:8]) & Status[0] & ~Status[1].
- FSM states: IDLE, DRAIN, ENTER, RETURN. A kind register (EXC or RET) and a latched epc_next travel with the FSM.
- IDLE priority (highest first):
  - syscall_wb & wb_valid: kind=EXC, code=8, epc_next=pc_wb+4 (wraps mod 2^32). Go to DRAIN.
  - eret_wb & wb_valid: kind=RET. Go to DRAIN.
  - irq_pending & wb_valid: kind=EXC, code=0, epc_next=pc_wb+4. Go to DRAIN.
  - mtc0_we & wb_valid: write to CP0.
    - Addr 12 writes bits [10:8], [1], [0].
    - Addr 14 writes all 32 bits.
    - Addr 13 and all other addresses are ignored.
- If an event and an mtc0 arrive together, the mtc0 is dropped.
- Outside IDLE, syscall, eret and mtc0 inputs are ignored. Interrupts stay pending because they are level-sensitive.
- DRAIN:
  - stall=1.
  - flush=1 on the first DRAIN cycle only.
  - Leaves when pipe_empty=1: to ENTER if kind=EXC, to RETURN if kind=RET.
- ENTER (one cycle):
  - stall=1, redirect_valid=1, redirect_pc=VECTOR_ADDR.
  - At the clock edge: EPC<=epc_next, ExcCode<=code, EXL<=1. Then go to IDLE.
- RETURN (one cycle):
  - stall=1, redirect_valid=1, redirect_pc=EPC.
  - At the clock edge: EXL<=0. Then go to IDLE.
- Nested exceptions are blocked by EXL. A syscall while EXL=1 is still taken and overwrites EPC.

## Timing
- Reset values:
  - Status, EPC = 0. Cause = IP only.
  - FSM in IDLE, kind = EXC.
  - stall, flush, redirect_valid = 0. redirect_pc = 0.
- rst asserted mid-sequence returns to IDLE at the next edge. It cancels any pending redirect, with no CP0 update.
- Event sampled at edge t:
  - DRAIN (flush=1) in cycle t+1.
  - If pipe_empty is already 1 in t+1: ENTER or RETURN in t+2, with redirect in t+2.
  - New CP0 values are visible from t+3.
- Minimum event-to-redirect latency is 2 cycles; otherwise it is unbounded and follows pipe_empty.
- mtc0 is written at the retiring edge. mfc0_rdata reflects it in the next cycle. There is no internal bypass.
- redirect_valid and flush are never high in the same cycle.

## Structure
- Package cp0_pkg holds:
  - state enum.
  - CP0 address constants 12/13/14.
  - ExcCode constants EXC_INT=0 and EXC_SYS=8.
  - Status/Cause bit-position constants.
- Single module. Sub-module cp0_regs (the three registers, write masks and read mux) is natural. FSM and priority logic stay in cp0_exc_ctrl.

## Test plan
- Reset, then idle: all outputs 0, Status=0, EPC=0, cause_out[10:8] equals int_req.
- Syscall at pc_wb=0x100 with pipe_empty=1:
  - flush in t+1.
  - redirect_pc=0x3000 in t+2.
  - Then EPC=0x104, Cause[6:2]=8, Status[1]=1.
- Eret after the syscall above: redirect_pc=0x104, Status[1]=0; pipe_empty held 0 for 3 cycles delays the redirect by exactly 3.
- mtc0 Status=0x0000_0201 then int_req=3'b010 with wb_valid at pc_wb=0x200: ENTER with Cause[6:2]=0, EPC=0x204. Same test with IM=0 or EXL=1: no entry.
- Syscall and mtc0 to EPC in the same cycle: the mtc0 is dropped. Syscall at pc_wb=0xFFFF_FFFC: EPC=0.
- rst asserted in DRAIN: no redirect, Status and EPC stay at reset values, FSM in IDLE.
